pwm_fade_controller: RTL and testbench
======================================

// Module: pwm_fade_controller
// PURPOSE
//  Sequencer that drives the 8-bit pwm_duty input of the PWM LED stage.
//  Accepts commands over a valid/ready handshake: set level, linear fade, continuous breathe, off.
//  Steps the duty register at a programmable clock-divided rate.
//  One instance sits in front of each LED channel's PWM block.
// PARAMETERS
//  DUTY_W      8   width of duty/level values (1 duty LSB per step)
//  RATE_W      16  width of cmd_rate (clocks per duty step)
// PORTS
//  clock       in   1        system clock, all logic on posedge
//  reset_n     in   1        asynchronous, active-low reset
//  cmd_valid   in   1        command present
//  cmd_ready   out  1        controller can accept a command
//  cmd_mode    in   2        00 SET, 01 FADE, 10 BREATHE, 11 OFF
//  cmd_level   in   DUTY_W   target level (SET/FADE) or peak level (BREATHE)
//  cmd_rate    in   RATE_W   clocks per duty step; 0 is treated as 1
//  pwm_duty    out  DUTY_W   duty value to the PWM stage
//  busy        out  1        1 while in FADE, BR_UP or BR_DOWN
//  done        out  1        one-cycle pulse when SET/OFF/FADE reaches its target
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; pwm_duty=0, busy=0, done=0, cmd_ready=0; prescaler=0.
//    Reset mid-fade/breathe abandons the sequence immediately.
//  - cmd_ready is registered: 1 when the next state is IDLE, BR_UP or BR_DOWN; 0 in FADE.
//    It goes to 1 on the first clock edge after reset_n rises.
//  - Accept = cmd_valid & cmd_ready. mode/level/rate are sampled on the accept edge.
//    The prescaler is cleared on every accept.
//  - States: IDLE, FADE, BR_UP, BR_DOWN.
//  - SET: on the accept edge, duty<=level, done=1; next state IDLE.
//  - OFF: same as SET with level 0.
//  - FADE, level==duty: done=1 on the accept edge; stay IDLE.
//  - FADE, otherwise: enter FADE.
//    Prescaler counts 0..rate-1; on the edge it hits rate-1 it wraps to 0 and duty steps 1 toward level.
//    The step that makes duty==level also sets done=1 and returns to IDLE.
//    A fade of N steps completes N*rate clocks after the accept edge.
//  - BREATHE, level==0: behaves as OFF.
//  - BREATHE, otherwise: enter BR_UP if duty<level, else BR_DOWN.
//    BR_UP: +1 per prescale tick; on the tick where duty becomes level, go to BR_DOWN.
//    BR_DOWN: -1 per tick; on the tick where duty becomes 0, go to BR_UP.
//    In BR_DOWN with duty>level on entry, the ramp first falls to 0.
//    Runs until a new command is accepted; done is never pulsed. busy=1 throughout.
//  - A command accepted during BR_UP/BR_DOWN takes effect on the accept edge, from the current duty.
//  - Duty arithmetic is saturating by construction and never wraps.
//    Steps only move toward an endpoint within 0..2^DUTY_W-1.
//  - done and cmd_ready can never both reflect the same accept. There is no simultaneous accept+done conflict:
//    done is generated only by the accepted command's own completion.
// CONFIGURATION
//  PWM_GAMMA_EN defined:
//    pwm_duty = registered (d*(d+1)) >> DUTY_W, where d is the internal duty register.
//    Mapping: 0->0, 1->0, 128->64, 255->255.
//    Adds 1 clock of latency to pwm_duty; done is delayed 1 clock to stay aligned.
//    The reset value of the output register is 0.
//  PWM_GAMMA_EN undefined: pwm_duty = d directly; no extra latency.
// TESTING
//  1. Reset released, idle -> pwm_duty=0, busy=0, done=0; cmd_ready=1 on the first edge after release.
//  2. SET level=200 -> pwm_duty=200 and done=1 on the accept edge; then OFF -> pwm_duty=0, done pulse.
//  3. FADE 0->10, rate=4 -> duty increments every 4 clocks.
//     Final step reaches 10 at 40 clocks with done=1; cmd_ready=0 throughout; rate=0 gives a step every clock.
//  4. BREATHE level=3, rate=1 from duty 0 -> duty sequence 1,2,3,2,1,0,1,2,3..., busy=1, no done.
//     FADE to 0 accepted mid-ramp -> duty descends from its current value.
//  5. Assert reset_n=0 mid-FADE at duty=5 -> outputs are 0 immediately (async); state is IDLE after release.
//  6. Gamma build (PWM_GAMMA_EN): SET 128 -> pwm_duty=64 one clock later with done aligned; SET 255 -> 255.

Source files
------------

// File: rtl/pwm_fade_controller.sv
// PWM fade/breathe sequencer feeding the duty input of one LED PWM stage.
// Commands (SET, FADE, BREATHE, OFF) arrive over a valid/ready handshake and
// step an internal duty register at a clock-divided rate.
// Optional build macro PWM_GAMMA_EN: registered square-law gamma on pwm_duty,
// with done delayed one clock to stay aligned with the output.
module pwm_fade_controller #(
    parameter int unsigned DUTY_W = 8,
    parameter int unsigned RATE_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [DUTY_W-1:0] cmd_level,
    input  logic [RATE_W-1:0] cmd_rate,
    output logic [DUTY_W-1:0] pwm_duty,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StFade, StBrUp, StBrDown} state_e;

    localparam logic [1:0] ModeSet     = 2'b00;
    localparam logic [1:0] ModeFade    = 2'b01;
    localparam logic [1:0] ModeBreathe = 2'b10;
    localparam logic [1:0] ModeOff     = 2'b11;

    localparam logic [RATE_W-1:0] RateOne = RATE_W'(1);
    localparam logic [DUTY_W-1:0] DutyOne = DUTY_W'(1);

    state_e              r_state;
    logic [DUTY_W-1:0]   r_duty;
    logic [DUTY_W-1:0]   r_level;
    logic [RATE_W-1:0]   r_rate;
    logic [RATE_W-1:0]   r_pre;
    logic                r_done;
    logic                r_ready;

    state_e              w_state_d;
    logic [DUTY_W-1:0]   w_duty_d;
    logic [DUTY_W-1:0]   w_level_d;
    logic [RATE_W-1:0]   w_rate_d;
    logic [RATE_W-1:0]   w_pre_d;
    logic                w_done_d;
    logic                w_ready_d;

    logic                w_accept;
    logic                w_tick;
    logic [DUTY_W-1:0]   w_up;
    logic [DUTY_W-1:0]   w_dn;

    assign w_accept = cmd_valid & r_ready;
    // r_rate is never 0, so rate-1 cannot underflow
    assign w_tick   = (r_pre == (r_rate - RateOne));
    assign w_up     = r_duty + DutyOne;
    assign w_dn     = r_duty - DutyOne;

    // Next-state, duty stepping and completion logic; accepted commands win over ramp ticks
    always_comb begin
        w_state_d = r_state;
        w_duty_d  = r_duty;
        w_level_d = r_level;
        w_rate_d  = r_rate;
        w_pre_d   = r_pre;
        w_done_d  = 1'b0;
        if (w_accept) begin
            w_pre_d   = '0;
            w_level_d = cmd_level;
            w_rate_d  = (cmd_rate == '0) ? RateOne : cmd_rate;
            case (cmd_mode)
                ModeSet: begin
                    w_duty_d  = cmd_level;
                    w_done_d  = 1'b1;
                    w_state_d = StIdle;
                end
                ModeFade: begin
                    if (cmd_level == r_duty) begin
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_state_d = StFade;
                    end
                end
                ModeBreathe: begin
                    if (cmd_level == '0) begin
                        w_duty_d  = '0;
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end else if (r_duty < cmd_level) begin
                        w_state_d = StBrUp;
                    end else begin
                        w_state_d = StBrDown;
                    end
                end
                ModeOff: begin
                    w_duty_d  = '0;
                    w_done_d  = 1'b1;
                    w_state_d = StIdle;
                end
                default: ;
            endcase
        end else if (r_state != StIdle) begin
            w_pre_d = w_tick ? '0 : (r_pre + RateOne);
            if (w_tick) begin
                case (r_state)
                    StFade: begin
                        if (r_duty < r_level) begin
                            w_duty_d = w_up;
                            if (w_up == r_level) begin
                                w_done_d  = 1'b1;
                                w_state_d = StIdle;
                            end
                        end else if (r_duty > r_level) begin
                            w_duty_d = w_dn;
                            if (w_dn == r_level) begin
                                w_done_d  = 1'b1;
                                w_state_d = StIdle;
                            end
                        end else begin
                            w_done_d  = 1'b1;
                            w_state_d = StIdle;
                        end
                    end
                    StBrUp: begin
                        if (r_duty < r_level) begin
                            w_duty_d = w_up;
                            if (w_up == r_level) begin
                                w_state_d = StBrDown;
                            end
                        end else begin
                            w_state_d = StBrDown;
                        end
                    end
                    StBrDown: begin
                        if (r_duty != '0) begin
                            w_duty_d = w_dn;
                            if (w_dn == '0) begin
                                w_state_d = StBrUp;
                            end
                        end else begin
                            w_state_d = StBrUp;
                        end
                    end
                    default: ;
                endcase
            end
        end
        w_ready_d = (w_state_d != StFade);
    end

    // State, duty, command and handshake registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_duty  <= '0;
            r_level <= '0;
            r_rate  <= RateOne;
            r_pre   <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_duty  <= w_duty_d;
            r_level <= w_level_d;
            r_rate  <= w_rate_d;
            r_pre   <= w_pre_d;
            r_done  <= w_done_d;
            r_ready <= w_ready_d;
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = (r_state != StIdle);

`ifdef PWM_GAMMA_EN
    logic [2*DUTY_W-1:0] w_prod;
    logic [DUTY_W-1:0]   w_gamma;
    logic [DUTY_W-1:0]   r_gamma;
    logic                r_done_dly;

    // d*(d+1) < 2^(2*DUTY_W), so the product never overflows
    assign w_prod  = (2*DUTY_W)'(r_duty) * ((2*DUTY_W)'(r_duty) + (2*DUTY_W)'(1));
    assign w_gamma = DUTY_W'(w_prod >> DUTY_W);

    // Gamma output register and matching done delay
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gamma    <= '0;
            r_done_dly <= 1'b0;
        end else begin
            r_gamma    <= w_gamma;
            r_done_dly <= r_done;
        end
    end

    assign pwm_duty = r_gamma;
    assign done     = r_done_dly;
`else
    assign pwm_duty = r_duty;
    assign done     = r_done;
`endif

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Directed self-checking bench for pwm_fade_controller.
module tb_pwm_fade_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = 2'b00;
    logic [7:0]  cmd_level = 8'd0;
    logic [15:0] cmd_rate = 16'd0;
    logic [7:0]  pwm_duty;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [1:0] MSet = 2'b00, MFade = 2'b01, MBreathe = 2'b10, MOff = 2'b11;

    pwm_fade_controller #(.DUTY_W(8), .RATE_W(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_level (cmd_level),
        .cmd_rate  (cmd_rate),
        .pwm_duty  (pwm_duty),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Waits (bounded) for cmd_ready, presents one command for one edge; returns 1ns after accept
    task automatic send(input logic [1:0] m, input logic [7:0] l, input logic [15:0] r);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(posedge clock); #1; n++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL send_ready timeout got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_mode = m; cmd_level = l; cmd_rate = r;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (pwm_duty !== 8'd0) begin n_fail++; $display("FAIL rst_duty got %0d want 0", pwm_duty); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", cmd_ready); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_pre got %b want 0", cmd_ready); end
        step();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready got %b want 1", cmd_ready); end
        n_cmp++; if (pwm_duty !== 8'd0) begin n_fail++; $display("FAIL rel_duty got %0d want 0", pwm_duty); end
    endtask

    task automatic test_set_off();
        send(MSet, 8'd200, 16'd0);
        n_cmp++; if (pwm_duty !== 8'd200) begin n_fail++; $display("FAIL set_duty got %0d want 200", pwm_duty); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL set_done got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL set_busy got %b want 0", busy); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL set_done_pulse got %b want 0", done); end
        n_cmp++; if (pwm_duty !== 8'd200) begin n_fail++; $display("FAIL set_hold got %0d want 200", pwm_duty); end
        send(MOff, 8'h55, 16'd3);
        n_cmp++; if (pwm_duty !== 8'd0) begin n_fail++; $display("FAIL off_duty got %0d want 0", pwm_duty); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL off_done got %b want 1", done); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL off_done_pulse got %b want 0", done); end
    endtask

    task automatic test_fade();
        send(MFade, 8'd10, 16'd4);
        n_cmp++; if (pwm_duty !== 8'd0) begin n_fail++; $display("FAIL fade_acc_duty got %0d want 0", pwm_duty); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fade_acc_busy got %b want 1", busy); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fade_acc_ready got %b want 0", cmd_ready); end
        for (int k = 1; k <= 40; k++) begin
            step();
            n_cmp++;
            if (pwm_duty !== 8'(k / 4)) begin
                n_fail++; $display("FAIL fade_duty clk %0d got %0d want %0d", k, pwm_duty, k / 4);
            end
            n_cmp++;
            if (done !== (k == 40)) begin
                n_fail++; $display("FAIL fade_done clk %0d got %b want %b", k, done, k == 40);
            end
            n_cmp++;
            if (cmd_ready !== (k == 40)) begin
                n_fail++; $display("FAIL fade_ready clk %0d got %b want %b", k, cmd_ready, k == 40);
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fade_end_busy got %b want 0", busy); end
    endtask

    task automatic test_fade_rate0();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'd9; exp_d[1] = 8'd8; exp_d[2] = 8'd7;
        send(MFade, 8'd7, 16'd0);
        n_cmp++; if (pwm_duty !== 8'd10) begin n_fail++; $display("FAIL r0_acc_duty got %0d want 10", pwm_duty); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (pwm_duty !== exp_d[k]) begin
                n_fail++; $display("FAIL r0_duty clk %0d got %0d want %0d", k + 1, pwm_duty, exp_d[k]);
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL r0_done got %b want 1", done); end
        // Fade to the current level completes at once
        send(MFade, 8'd7, 16'd5);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL feq_done got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL feq_busy got %b want 0", busy); end
        n_cmp++; if (pwm_duty !== 8'd7) begin n_fail++; $display("FAIL feq_duty got %0d want 7", pwm_duty); end
    endtask

    task automatic test_breathe();
        logic [7:0] seq [10];
        seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 2; seq[4] = 1;
        seq[5] = 0; seq[6] = 1; seq[7] = 2; seq[8] = 3; seq[9] = 2;
        send(MSet, 8'd0, 16'd0);
        send(MBreathe, 8'd3, 16'd1);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL br_acc_busy got %b want 1", busy); end
        n_cmp++; if (pwm_duty !== 8'd0) begin n_fail++; $display("FAIL br_acc_duty got %0d want 0", pwm_duty); end
        for (int k = 0; k < 10; k++) begin
            step();
            n_cmp++;
            if (pwm_duty !== seq[k]) begin
                n_fail++; $display("FAIL br_duty clk %0d got %0d want %0d", k + 1, pwm_duty, seq[k]);
            end
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL br_flags clk %0d got done=%b busy=%b want 0/1", k + 1, done, busy);
            end
        end
        // Fade to 0 accepted mid-ramp at duty 2, rate 2
        send(MFade, 8'd0, 16'd2);
        n_cmp++; if (pwm_duty !== 8'd2) begin n_fail++; $display("FAIL brf_acc_duty got %0d want 2", pwm_duty); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL brf_ready got %b want 0", cmd_ready); end
        step();
        n_cmp++; if (pwm_duty !== 8'd2) begin n_fail++; $display("FAIL brf_d1 got %0d want 2", pwm_duty); end
        step();
        n_cmp++; if (pwm_duty !== 8'd1) begin n_fail++; $display("FAIL brf_d2 got %0d want 1", pwm_duty); end
        step();
        step();
        n_cmp++; if (pwm_duty !== 8'd0) begin n_fail++; $display("FAIL brf_d4 got %0d want 0", pwm_duty); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL brf_done got %b want 1", done); end
    endtask

    task automatic test_async_reset();
        send(MFade, 8'd20, 16'd1);
        for (int k = 0; k < 5; k++) step();
        n_cmp++; if (pwm_duty !== 8'd5) begin n_fail++; $display("FAIL ar_pre_duty got %0d want 5", pwm_duty); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (pwm_duty !== 8'd0) begin n_fail++; $display("FAIL ar_duty got %0d want 0", pwm_duty); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got %b want 0", busy); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ar_ready got %b want 0", cmd_ready); end
        step();
        step();
        reset_n = 1'b1;
        step();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ar_rel_ready got %b want 1", cmd_ready); end
        step();
        step();
        n_cmp++; if (pwm_duty !== 8'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ar_idle got duty=%0d busy=%b want 0/0", pwm_duty, busy);
        end
    endtask

`ifdef PWM_GAMMA_EN
    task automatic test_gamma();
        send(MSet, 8'd128, 16'd0);
        n_cmp++; if (pwm_duty !== 8'd0) begin n_fail++; $display("FAIL g_acc_duty got %0d want 0", pwm_duty); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL g_acc_done got %b want 0", done); end
        step();
        n_cmp++; if (pwm_duty !== 8'd64) begin n_fail++; $display("FAIL g128_duty got %0d want 64", pwm_duty); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL g128_done got %b want 1", done); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL g_done_pulse got %b want 0", done); end
        send(MSet, 8'd255, 16'd0);
        step();
        n_cmp++; if (pwm_duty !== 8'd255) begin n_fail++; $display("FAIL g255_duty got %0d want 255", pwm_duty); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL g255_done got %b want 1", done); end
        send(MSet, 8'd1, 16'd0);
        step();
        n_cmp++; if (pwm_duty !== 8'd0) begin n_fail++; $display("FAIL g1_duty got %0d want 0", pwm_duty); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PWM_GAMMA_EN
        test_gamma();
`else
        test_set_off();
        test_fade();
        test_fade_rate0();
        test_breathe();
        test_async_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
